pipelined_add_sub: RTL
======================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter: STAGES, 2, number of pipeline stages; legal values 1..4; WIDTH SHALL be divisible by STAGES.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operand set on in_a/in_b/in_op is valid.
REQ-006 Port: in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B.
REQ-009 Port: in_op  input  2  00 ADD, 01 SUB, 10 ADDU, 11 SUBU.
REQ-010 Port: out_valid  output  1  result fields are valid.
REQ-011 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-012 Port: out_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 Port: out_carry  output  1  carry out of the MSB; for SUB/SUBU, 1 = no borrow.
REQ-014 Port: out_ovf  output  1  signed overflow; forced to 0 for ADDU/SUBU.
REQ-015 Port: out_zero  output  1  out_result equals 0.

Function
REQ-016 ADD/ADDU SHALL compute A+B+0; SUB/SUBU SHALL compute A+~B+1.
REQ-017 The carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits each, least-significant slice first.
REQ-018 Stage k SHALL register the slice-k sum and carry, and delay the unused upper operand slices, the op code and the valid bit by one stage.
REQ-019 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1 when there is no stall.
REQ-020 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-021 Input transfer SHALL occur on an edge where in_valid=1 and in_ready=1; output transfer SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-022 in_ready SHALL equal (!out_valid || out_ready), with the pipeline advancing globally on that enable.
REQ-023 When the enable is 0, every stage, including the output fields, SHALL hold.
REQ-024 While out_valid=1 and out_ready=0, out_result, out_carry, out_ovf and out_zero SHALL remain stable.
REQ-025 Bubbles (in_valid=0 on an advance) SHALL propagate as stages with valid=0 and SHALL NOT be collapsed.
REQ-026 out_ovf for ADD/SUB SHALL be 1 when the effective operand sign bits (A and B, or A and ~B) are equal and the result sign differs from them.
REQ-027 out_zero SHALL be derived from the final registered result.
REQ-028 No combinational path SHALL exist from in_* to out_*; in_ready depends only on out_valid and out_ready.
REQ-029 Results SHALL leave the block in acceptance order, and no accepted operation SHALL be dropped or duplicated.
REQ-030 With STAGES=1 the block SHALL behave as a single registered stage with latency 1.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately clear all stage valid bits, giving out_valid=0 and, with out_ready=1, in_ready=1.
REQ-032 During reset, out_result SHALL be 0, out_carry 0, out_ovf 0 and out_zero 1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight operations, and none SHALL appear after rst_n returns to 1.
REQ-034 The first edge after rst_n deasserts SHALL be able to accept an input.

Verification (WIDTH=32, STAGES=2 unless noted)
REQ-035 ADD 0x7FFFFFFF + 0x00000001 -> 2 cycles later out_result=0x80000000, carry=0, ovf=1, zero=0; the same operands with ADDU give ovf=0.
REQ-036 ADD 0xFFFFFFFF + 0x00000001 -> out_result=0x00000000, carry=1, ovf=0, zero=1; exercises the inter-slice carry.
REQ-037 SUB 5 - 7 -> 0xFFFFFFFE, carry=0, ovf=0; SUB 0x80000000 - 1 -> 0x7FFFFFFF, carry=1, ovf=1; SUBU of the second case gives ovf=0.
REQ-038 Stall check: four back-to-back ops with out_ready=0 for 3 cycles after the first result -> in_ready=0 while out_valid=1, the first result is held stable, and all four results appear in order with no loss.
REQ-039 Reset check: pulse rst_n low for 1 cycle with 2 ops in flight -> out_valid falls without waiting for a clock, and no result appears for those ops afterwards.
REQ-040 Random regression: compare against a reference model for STAGES in {1,2,4} and WIDTH in {8,32,64} with random in_valid/out_ready; all flags SHALL match.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined add/subtract with a sliced carry chain and valid/ready flow control
//
// Purpose: computes A+B (ADD/ADDU) or A+~B+1 (SUB/SUBU). The carry chain is cut into
// STAGES slices of WIDTH/STAGES bits, one slice resolved per pipeline stage, least-significant first.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set on in_a/in_b/in_op is valid
//   in_ready   block accepts an operand set this cycle (= !out_valid || out_ready)
//   in_a/in_b  operands, WIDTH bits
//   in_op      00 ADD, 01 SUB, 10 ADDU, 11 SUBU
//   out_valid  result fields are valid
//   out_ready  downstream accepts the result this cycle
//   out_result sum/difference modulo 2^WIDTH
//   out_carry  carry out of the MSB (1 = no borrow for subtraction)
//   out_ovf    signed overflow, 0 for unsigned ops
//   out_zero   out_result == 0
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW = WIDTH / STAGES;

  // Whole pipeline advances together; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // REM: operand bits still to be summed entering this stage.
    // LO:  result bits known after this stage.
    localparam int REM = WIDTH - k * SW;
    localparam int LO  = (k + 1) * SW;

    logic [REM-1:0] a_in;
    logic [REM-1:0] b_in;
    logic           c_in;
    logic           uns_in;
    logic           v_in;
    logic [SW:0]    slice_sum;
    logic [LO-1:0]  res_nxt;
    logic [LO-1:0]  res_q;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_head
      // Subtraction folds into addition: invert B here and inject the +1 as carry-in.
      assign a_in    = in_a;
      assign b_in    = in_op[0] ? ~in_b : in_b;
      assign c_in    = in_op[0];
      assign uns_in  = in_op[1];
      assign v_in    = in_valid;
      assign res_nxt = slice_sum[SW-1:0];
    end else begin : g_chain
      assign a_in    = stg[k-1].g_pass.a_q;
      assign b_in    = stg[k-1].g_pass.b_q;
      assign c_in    = stg[k-1].c_q;
      assign uns_in  = stg[k-1].g_pass.uns_q;
      assign v_in    = stg[k-1].v_q;
      assign res_nxt = {slice_sum[SW-1:0], stg[k-1].res_q};
    end

    assign slice_sum = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= slice_sum[SW];
        res_q <= res_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      // Only the not-yet-summed upper slices travel on.
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;
      logic              uns_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          uns_q <= 1'b0;
        end else if (adv) begin
          a_q   <= a_in[REM-1:SW];
          b_q   <= b_in[REM-1:SW];
          uns_q <= uns_in;
        end
      end
    end else begin : g_last
      // Top slice holds the sign bits; b_in is already the effective (possibly inverted) B.
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= !uns_in && (a_in[REM-1] == b_in[REM-1]) && (slice_sum[SW-1] != a_in[REM-1]);
        end
      end
    end
  end

  assign out_valid  = stg[STAGES-1].v_q;
  assign out_result = stg[STAGES-1].res_q;
  assign out_carry  = stg[STAGES-1].c_q;
  assign out_ovf    = stg[STAGES-1].g_last.ovf_q;
  assign out_zero   = (out_result == '0);

endmodule
